// File: rtl/fixed_point_div.sv
// Sequential signed Q16.16 restoring divider, one quotient bit per clock, saturating result and flags.
// Define FXDIV_ROUND_EN to compute one extra bit and round half away from zero.
module fixed_point_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic        overflow,
  output logic        div_by_zero
);

`ifdef FXDIV_ROUND_EN
  localparam int unsigned N = 49;
`else
  localparam int unsigned N = 48;
`endif
  localparam logic [5:0] CNT_INIT = 6'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q;
  logic        sign_q;
  logic [32:0] divisor_q;
  logic [32:0] rem_q;
  logic [47:0] dividend_q;
  logic [48:0] qmag_q;
  logic [5:0]  cnt_q;

  logic [32:0] a_ext, b_ext, abs_a, abs_b;
  logic [33:0] trial;
  logic        fits;
  logic [32:0] rem_d;
  logic [48:0] qmag_d;
  logic [48:0] mag;
  logic [48:0] limit;
  logic [31:0] fix_quot_d;
  logic        fix_ovf_d;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  always_comb begin
    a_ext = {a[31], a};
    b_ext = {b[31], b};
    abs_a = a[31] ? -a_ext : a_ext;
    abs_b = b[31] ? -b_ext : b_ext;

    // Remainder stays below |b| <= 2^31, so the shifted trial fits comfortably.
    trial  = {rem_q, dividend_q[47]};
    fits   = (trial >= {1'b0, divisor_q});
    rem_d  = fits ? 33'(trial - {1'b0, divisor_q}) : trial[32:0];
    qmag_d = {qmag_q[47:0], fits};

`ifdef FXDIV_ROUND_EN
    mag = {1'b0, qmag_q[48:1]} + {48'd0, qmag_q[0]};
`else
    mag = qmag_q;
`endif
    limit     = sign_q ? 49'h0_8000_0000 : 49'h0_7FFF_FFFF;
    fix_ovf_d = (mag > limit);
    if (fix_ovf_d) begin
      fix_quot_d = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      fix_quot_d = sign_q ? -mag[31:0] : mag[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      divisor_q   <= '0;
      rem_q       <= '0;
      dividend_q  <= '0;
      qmag_q      <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q     <= a[31] ^ b[31];
            divisor_q  <= abs_b;
            dividend_q <= 48'({abs_a, 16'h0000});
            rem_q      <= '0;
            qmag_q     <= '0;
            cnt_q      <= CNT_INIT;
            if (b == 32'd0) begin
              quotient    <= a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
              overflow    <= 1'b0;
              div_by_zero <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q      <= rem_d;
          qmag_q     <= qmag_d;
          dividend_q <= dividend_q << 1;
          cnt_q      <= cnt_q - 6'd1;
          if (cnt_q == 6'd0) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          quotient    <= fix_quot_d;
          overflow    <= fix_ovf_d;
          div_by_zero <= 1'b0;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_div.sv
// Directed bench for fixed_point_div; expected values follow FXDIV_ROUND_EN when defined.
module tb_fixed_point_div;

`ifdef FXDIV_ROUND_EN
  localparam int          LAT  = 51;
  localparam logic [31:0] Q23  = 32'h0000_AAAB;
  localparam logic [31:0] QN23 = 32'hFFFF_5555;
`else
  localparam int          LAT  = 50;
  localparam logic [31:0] Q23  = 32'h0000_AAAA;
  localparam logic [31:0] QN23 = 32'hFFFF_5556;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic        overflow;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;

  fixed_point_div dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .overflow   (overflow),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_quotient"}, quotient, 32'd0);
    check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    check({tag, "_div_by_zero"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  // Drive operands until accepted; returns at the negedge after the accepting edge.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v, input string tag);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    a        = ta;
    b        = tb_v;
    n        = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = 32'hDEAD_BEEF;
    b        = 32'h0000_0000;
  endtask

  // Called at the first negedge after acceptance, which counts as cycle 1.
  task automatic wait_result(input int exp_lat, input string tag);
    int cyc;
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
  endtask

  task automatic check_res(input logic [31:0] eq, input logic eo, input logic ed, input string tag);
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, eo});
    check({tag, "_div_by_zero"}, {31'd0, div_by_zero}, {31'd0, ed});
  endtask

  task automatic consume(input string tag);
    check({tag, "_busy_ready"}, {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_consumed_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_consumed_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_div(input logic [31:0] ta, input logic [31:0] tb_v, input logic [31:0] eq,
                         input logic eo, input logic ed, input int lat, input string tag);
    issue(ta, tb_v, tag);
    wait_result(lat, tag);
    check_res(eq, eo, ed, tag);
    consume(tag);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    run_div(32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, LAT, "div3_2");
    run_div(32'h0002_0000, 32'h0003_0000, Q23,           1'b0, 1'b0, LAT, "div2_3");
    run_div(32'hFFFE_0000, 32'h0003_0000, QN23,          1'b0, 1'b0, LAT, "divm2_3");
    run_div(32'h7FFF_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, LAT, "ovf_pos");
    run_div(32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0, LAT, "min_by_one");
    run_div(32'h0005_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1,   "dz_pos");
    run_div(32'hFFFB_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 1,   "dz_neg");

    // Result held under backpressure, then back-to-back request during the consume cycle.
    issue(32'h0003_0000, 32'h0002_0000, "hold");
    wait_result(LAT, "hold");
    check_res(32'h0001_8000, 1'b0, 1'b0, "hold");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_quotient", quotient, 32'h0001_8000);
      check("hold_ctrl", {28'd0, out_valid, in_ready, overflow, div_by_zero}, 32'b1000);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = 32'h0002_0000;
    b         = 32'h0003_0000;
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_consumed_valid", {31'd0, out_valid}, 32'd0);
    check("b2b_ready_after_consume", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_accepted", {31'd0, in_ready}, 32'd0);
    wait_result(LAT, "b2b");
    check_res(Q23, 1'b0, 1'b0, "b2b");
    consume("b2b");

    // Reset in the middle of CALC discards the in-flight result.
    issue(32'h0002_0000, 32'h0003_0000, "rst_mid");
    repeat (9) @(negedge clk);
    check("rst_mid_busy", {31'd0, in_ready}, 32'd0);
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_reset("rst_mid");
    run_div(32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, LAT, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
